// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param
// Description : Parametrised integer register file with x0 hardwired to zero,
//               two combinational read ports, one write port, and a one-register-
//               per-cycle clear sweep. Optional write-to-read forwarding is
//               compiled in with REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              clr_req,
    output logic              ready
);

    localparam int                NREGS      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic              w_clr_wr;
    logic              w_run_wr;
    logic              w_byp1;
    logic              w_byp2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    // Pointer wraps to 0 naturally on the last index.
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == c_LAST_IDX) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_ready   <= 1'b0;
                        r_clr_ptr <= '0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // A clear request in the same cycle as a write drops the write.
    assign w_clr_wr = (r_state == S_CLEAR);
    assign w_run_wr = (r_state == S_RUN) && we && (wa != '0) && !clr_req;

    // Storage carries no reset; the sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_run_wr) begin
            r_mem[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_run_wr && (wa == ra1);
    assign w_byp2 = w_run_wr && (wa == ra2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign rd1   = (!r_ready || (ra1 == '0)) ? '0 : (w_byp1 ? wd : r_mem[ra1]);
    assign rd2   = (!r_ready || (ra2 == '0)) ? '0 : (w_byp2 ? wd : r_mem[ra2]);
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_param
// Description : Self-checking bench for regfile_param against an array-based
//               reference model; honours REGFILE_BYPASS_EN for forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          clr_req;
    logic          ready;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: register contents, whether the file is usable, and
    // how many sweep edges remain before it becomes usable.
    logic [DW-1:0] m_mem [N];
    bit            m_ready;
    int            m_clr_left;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .clr_req (clr_req),
        .ready   (ready)
    );

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
        if (!m_ready || ra == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && !clr_req && wa != '0 && wa == ra) return wd;
`endif
        return m_mem[ra];
    endfunction

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        #1;
        cmp({tag, ".ready"}, DW'(ready), DW'(m_ready));
        cmp({tag, ".rd1"}, rd1, exp_rd(ra1));
        cmp({tag, ".rd2"}, rd2, exp_rd(ra2));
    endtask

    // One rising edge; the model applies the rules to the inputs sampled there.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (!m_ready) begin
                m_clr_left--;
                if (m_clr_left == 0) begin
                    m_ready = 1'b1;
                    foreach (m_mem[i]) m_mem[i] = '0;
                end
            end else if (clr_req) begin
                m_ready    = 1'b0;
                m_clr_left = N;
            end else if (we && wa != '0) begin
                m_mem[wa] = wd;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        reset      = 1'b0;
        m_ready    = 1'b0;
        m_clr_left = N;
    endtask

    task automatic idle();
        we = 1'b0; clr_req = 1'b0; wa = '0; wd = '0;
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        idle();
        ra1 = 5'd3; ra2 = 5'd17;
        assert_reset();

        // Reset held for three edges: outputs forced low.
        for (int e = 0; e < 3; e++) begin
            tick();
            check("reset");
            cmp("reset.rd1_zero", rd1, '0);
        end

        // Power-up sweep with writes to reg 9 and clear requests that must be ignored.
        reset = 1'b1;
        for (int e = 1; e <= N; e++) begin
            we = 1'b1; wa = 5'd9; wd = $urandom; clr_req = 1'($urandom_range(0, 1));
            ra1 = AW'($urandom); ra2 = 5'd9;
            check("sweep");
            tick();
            cmp("sweep.ready_edge", DW'(ready), DW'(e == N));
        end
        idle();
        ra1 = 5'd9;
        check("post_sweep");
        cmp("clear_ignores_we", rd1, '0);

        // Directed write / read back on both ports.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd5;
        check("wr5_same");
        tick();
        idle();
        check("wr5_after");
        cmp("wr5.rd1", rd1, 32'hDEADBEEF);
        cmp("wr5.rd2", rd2, 32'hDEADBEEF);

        // Writes to x0 are discarded.
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0;
        tick();
        idle();
        check("x0");
        cmp("x0.rd1", rd1, '0);

        // Same-cycle read of a register being written.
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd5;
        check("wr7_same");
`ifdef REGFILE_BYPASS_EN
        cmp("wr7.bypass", rd1, 32'hA5A5A5A5);
`else
        cmp("wr7.nobypass", rd1, '0);
`endif
        tick();
        idle();
        check("wr7_after");

        // Randomised traffic with occasional clear requests.
        for (int c = 0; c < 300; c++) begin
            we = 1'($urandom_range(0, 1)); wa = AW'($urandom); wd = $urandom;
            ra1 = AW'($urandom); ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            check("random");
            tick();
        end
        idle();
        for (int e = 0; e <= N; e++) tick();
        check("settle");
        cmp("settle.ready", DW'(ready), 32'd1);

        // Fill with index, then clear request racing a write to reg 3.
        for (int i = 1; i < N; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(i);
            tick();
        end
        idle();
        for (int i = 1; i < N; i += 6) begin
            ra1 = AW'(i); ra2 = AW'(N - i);
            check("fill");
        end
        we = 1'b1; wa = 5'd3; wd = 32'hFF; clr_req = 1'b1; ra1 = 5'd3; ra2 = 5'd4;
        check("clr_race_same");
        tick();
        idle();
        cmp("clr.ready_fall", DW'(ready), '0);
        for (int e = 1; e <= N; e++) begin
            tick();
            cmp("clr.ready_edge", DW'(ready), DW'(e == N));
        end
        for (int i = 0; i < N; i++) begin
            ra1 = AW'(i); ra2 = AW'(N - 1 - i);
            check("after_clr");
            cmp("after_clr.rd1_zero", rd1, '0);
        end

        // Reset asserted at sweep edge 10 restarts a full sweep.
        we = 1'b1; wa = 5'd12; wd = 32'h5555AAAA;
        tick();
        idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        assert_reset();
        ra1 = 5'd12; ra2 = 5'd12;
        check("mid_reset");
        tick();
        tick();
        check("mid_reset_held");
        reset = 1'b1;
        for (int e = 1; e <= N; e++) begin
            tick();
            cmp("rst_sweep.ready_edge", DW'(ready), DW'(e == N));
        end
        check("rst_sweep_done");
        cmp("rst_sweep.reg12", rd1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
